// File: rtl/ctrl_pkg.sv
// Shared constants for the pipelined RV32I control unit: opcodes, ALU-op codes,
// control-word bit positions and forwarding-select encodings.
package ctrl_pkg;

    localparam int CW_W = 9;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_LUI   = 2'b11;

    // Control word is {aluop[1:0], alusrc, mem_re, mem_we, reg_we, mem_to_reg, is_branch, is_jump}
    localparam int CW_JUMP       = 0;
    localparam int CW_BRANCH     = 1;
    localparam int CW_MEM_TO_REG = 2;
    localparam int CW_REG_WE     = 3;
    localparam int CW_MEM_WE     = 4;
    localparam int CW_MEM_RE     = 5;
    localparam int CW_ALUSRC     = 6;
    localparam int CW_ALUOP_LO   = 7;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef logic [CW_W-1:0] cw_t;

    function automatic cw_t make_cw(input logic [1:0] aluop, input logic alusrc, mem_re, mem_we,
                                    reg_we, mem_to_reg, is_branch, is_jump);
        return {aluop, alusrc, mem_re, mem_we, reg_we, mem_to_reg, is_branch, is_jump};
    endfunction

    function automatic logic op_decodable(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control word plus which source registers are read.
// The illegal flag exists only when CTRL_ILLEGAL_TRAP_EN is defined.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output cw_t        o_cw,
    output logic       o_uses_rs1,
    output logic       o_uses_rs2
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic       o_illegal
`endif
);

    // Opcode to control word; unknown opcodes become an all-zero bubble word
    always_comb begin
        o_cw       = {CW_W{1'b0}};
        o_uses_rs1 = 1'b0;
        o_uses_rs2 = 1'b0;
        case (i_opcode)
            OP_R:      begin o_cw = make_cw(ALUOP_FUNCT, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                             o_uses_rs1 = 1'b1; o_uses_rs2 = 1'b1; end
            OP_I:      begin o_cw = make_cw(ALUOP_FUNCT, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                             o_uses_rs1 = 1'b1; end
            OP_LOAD:   begin o_cw = make_cw(ALUOP_ADD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
                             o_uses_rs1 = 1'b1; end
            OP_STORE:  begin o_cw = make_cw(ALUOP_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                             o_uses_rs1 = 1'b1; o_uses_rs2 = 1'b1; end
            OP_BRANCH: begin o_cw = make_cw(ALUOP_BR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                             o_uses_rs1 = 1'b1; o_uses_rs2 = 1'b1; end
            OP_JAL:    begin o_cw = make_cw(ALUOP_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); end
            OP_JALR:   begin o_cw = make_cw(ALUOP_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
                             o_uses_rs1 = 1'b1; end
            OP_LUI:    begin o_cw = make_cw(ALUOP_LUI, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); end
            OP_AUIPC:  begin o_cw = make_cw(ALUOP_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); end
            default:   begin o_cw = {CW_W{1'b0}}; end
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign o_illegal = ~op_decodable(i_opcode) | (i_opcode[1:0] != 2'b11);
`endif

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined RV32I control unit: ID decode, EX/MEM/WB control registers, load-use and
// RAW stalls, EX forwarding selects, flush bubbles. Optional sticky illegal_o under CTRL_ILLEGAL_TRAP_EN.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int RF_ADDR_W = 5,
    parameter int FWD_EN    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 id_valid_i,
    input  logic [31:0]          id_instr_i,
    input  logic                 flush_i,
    input  logic                 mem_stall_i,
    output logic                 id_stall_o,
    output logic                 ex_valid_o,
    output logic [CW_W-1:0]      ex_cw_o,
    output logic [1:0]           fwd_a_o,
    output logic [1:0]           fwd_b_o,
    output logic                 mem_valid_o,
    output logic                 mem_re_o,
    output logic                 mem_we_o,
    output logic                 wb_reg_we_o,
    output logic                 wb_mem_to_reg_o,
    output logic [RF_ADDR_W-1:0] wb_rd_o
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                 illegal_o
`endif
);

    localparam logic [RF_ADDR_W-1:0] X0 = {RF_ADDR_W{1'b0}};

    function automatic logic rd_hit(input logic we, input logic [RF_ADDR_W-1:0] rd,
                                    input logic [RF_ADDR_W-1:0] rs);
        return we && (rd != X0) && (rd == rs);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic ex_we, input logic [RF_ADDR_W-1:0] ex_rd,
                                           input logic mem_we, input logic [RF_ADDR_W-1:0] mem_rd,
                                           input logic [RF_ADDR_W-1:0] rs);
        if (rd_hit(ex_we, ex_rd, rs))        return FWD_MEM;
        else if (rd_hit(mem_we, mem_rd, rs)) return FWD_WB;
        else                                 return FWD_RF;
    endfunction

    cw_t                  w_id_cw;
    logic                 w_uses_rs1, w_uses_rs2;
    logic [RF_ADDR_W-1:0] w_id_rd, w_id_rs1, w_id_rs2;
    logic                 w_unused_instr;
    logic                 w_load_use, w_raw, w_hazard, w_take;
    cw_t                  w_nx_cw;
    logic [RF_ADDR_W-1:0] w_nx_rd, w_nx_rs1, w_nx_rs2;
    logic [1:0]           w_nx_fwd_a, w_nx_fwd_b;

    logic                 r_ex_valid;
    cw_t                  r_ex_cw;
    logic [RF_ADDR_W-1:0] r_ex_rd;
    logic                 r_mem_valid, r_mem_re, r_mem_we, r_mem_reg_we, r_mem_mem_to_reg;
    logic [RF_ADDR_W-1:0] r_mem_rd;
    logic                 r_wb_reg_we, r_wb_mem_to_reg;
    logic [RF_ADDR_W-1:0] r_wb_rd;
    logic [1:0]           r_fwd_a, r_fwd_b;

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic                 w_illegal;
    logic                 r_illegal;
`endif

    ctrl_decode u_decode (
        .i_opcode   (id_instr_i[6:0]),
        .o_cw       (w_id_cw),
        .o_uses_rs1 (w_uses_rs1),
        .o_uses_rs2 (w_uses_rs2)
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        .o_illegal  (w_illegal)
`endif
    );

    // Unread source fields are zeroed so they can never match a destination
    assign w_id_rd        = id_instr_i[7 +: RF_ADDR_W];
    assign w_id_rs1       = w_uses_rs1 ? id_instr_i[15 +: RF_ADDR_W] : X0;
    assign w_id_rs2       = w_uses_rs2 ? id_instr_i[20 +: RF_ADDR_W] : X0;
    assign w_unused_instr = ^{id_instr_i[31:25], id_instr_i[14:12]};

    // Hazard detection and next-state of the EX stage and its forwarding selects
    always_comb begin
        w_load_use = id_valid_i & r_ex_valid & r_ex_cw[CW_MEM_RE] &
                     (rd_hit(1'b1, r_ex_rd, w_id_rs1) | rd_hit(1'b1, r_ex_rd, w_id_rs2));
        w_raw      = id_valid_i &
                     (rd_hit(r_ex_valid & r_ex_cw[CW_REG_WE], r_ex_rd, w_id_rs1) |
                      rd_hit(r_ex_valid & r_ex_cw[CW_REG_WE], r_ex_rd, w_id_rs2) |
                      rd_hit(r_mem_valid & r_mem_reg_we, r_mem_rd, w_id_rs1) |
                      rd_hit(r_mem_valid & r_mem_reg_we, r_mem_rd, w_id_rs2));
        if (FWD_EN != 0) begin
            w_hazard = w_load_use;
        end else begin
            w_hazard = w_load_use | w_raw;
        end
        w_take = id_valid_i & ~flush_i & ~w_hazard;
        if (w_take) begin
            w_nx_cw  = w_id_cw;
            w_nx_rd  = w_id_rd;
            w_nx_rs1 = w_id_rs1;
            w_nx_rs2 = w_id_rs2;
        end else begin
            w_nx_cw  = {CW_W{1'b0}};
            w_nx_rd  = X0;
            w_nx_rs1 = X0;
            w_nx_rs2 = X0;
        end
        // Selects are computed against the stages the current EX/MEM will occupy after the edge
        if (FWD_EN != 0) begin
            w_nx_fwd_a = fwd_sel(r_ex_valid & r_ex_cw[CW_REG_WE], r_ex_rd,
                                 r_mem_valid & r_mem_reg_we, r_mem_rd, w_nx_rs1);
            w_nx_fwd_b = fwd_sel(r_ex_valid & r_ex_cw[CW_REG_WE], r_ex_rd,
                                 r_mem_valid & r_mem_reg_we, r_mem_rd, w_nx_rs2);
        end else begin
            w_nx_fwd_a = FWD_RF;
            w_nx_fwd_b = FWD_RF;
        end
    end

    assign id_stall_o = mem_stall_i | (w_hazard & ~flush_i);

    // Stage registers: advance together unless data memory stalls
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ex_valid       <= 1'b0;
            r_ex_cw          <= {CW_W{1'b0}};
            r_ex_rd          <= X0;
            r_mem_valid      <= 1'b0;
            r_mem_re         <= 1'b0;
            r_mem_we         <= 1'b0;
            r_mem_reg_we     <= 1'b0;
            r_mem_mem_to_reg <= 1'b0;
            r_mem_rd         <= X0;
            r_wb_reg_we      <= 1'b0;
            r_wb_mem_to_reg  <= 1'b0;
            r_wb_rd          <= X0;
            r_fwd_a          <= FWD_RF;
            r_fwd_b          <= FWD_RF;
        end else if (!mem_stall_i) begin
            r_ex_valid       <= w_take;
            r_ex_cw          <= w_nx_cw;
            r_ex_rd          <= w_nx_rd;
            r_mem_valid      <= r_ex_valid;
            r_mem_re         <= r_ex_cw[CW_MEM_RE];
            r_mem_we         <= r_ex_cw[CW_MEM_WE];
            r_mem_reg_we     <= r_ex_cw[CW_REG_WE];
            r_mem_mem_to_reg <= r_ex_cw[CW_MEM_TO_REG];
            r_mem_rd         <= r_ex_rd;
            r_wb_reg_we      <= r_mem_reg_we;
            r_wb_mem_to_reg  <= r_mem_mem_to_reg;
            r_wb_rd          <= r_mem_rd;
            r_fwd_a          <= w_nx_fwd_a;
            r_fwd_b          <= w_nx_fwd_b;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    // Sticky trap flag, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_illegal <= 1'b0;
        end else if (id_valid_i && !flush_i && w_illegal) begin
            r_illegal <= 1'b1;
        end
    end
    assign illegal_o = r_illegal;
`endif

    assign ex_valid_o      = r_ex_valid;
    assign ex_cw_o         = r_ex_cw;
    assign fwd_a_o         = r_fwd_a;
    assign fwd_b_o         = r_fwd_b;
    assign mem_valid_o     = r_mem_valid;
    assign mem_re_o        = r_mem_re;
    assign mem_we_o        = r_mem_we;
    assign wb_reg_we_o     = r_wb_reg_we;
    assign wb_mem_to_reg_o = r_wb_mem_to_reg;
    assign wb_rd_o         = r_wb_rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: opcode table through a pipeline scoreboard, plus
// hand sequences for reset, load-use, forwarding, flush and memory stall (CTRL_ILLEGAL_TRAP_EN optional).
module tb_ctrl_pipe;

    localparam logic [6:0] T_R = 7'b0110011, T_I = 7'b0010011, T_LD = 7'b0000011,
                           T_ST = 7'b0100011, T_BR = 7'b1100011, T_JAL = 7'b1101111,
                           T_JALR = 7'b1100111, T_LUI = 7'b0110111, T_AUIPC = 7'b0010111;
    localparam logic [8:0] CW_R = 9'b101001000, CW_LD = 9'b000101100, CW_ST = 9'b000010000,
                           CW_LUI = 9'b110001000;

    typedef struct { logic [6:0] op; logic [8:0] cw; } vec_t;
    typedef struct packed { logic valid; logic [8:0] cw; logic [4:0] rd; } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, id_valid, flush, mem_stall;
    logic [31:0] instr;
    logic        stall, ex_valid, mem_valid, mem_re, mem_we, wb_we, wb_m2r;
    logic [8:0]  ex_cw;
    logic [1:0]  fwd_a, fwd_b;
    logic [4:0]  wb_rd;
    logic        nf_stall, nf_ex_valid, nf_mem_valid, nf_mem_re, nf_mem_we, nf_wb_we, nf_wb_m2r;
    logic [8:0]  nf_ex_cw;
    logic [1:0]  nf_fwd_a, nf_fwd_b;
    logic [4:0]  nf_wb_rd;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic        illegal, nf_illegal;
`endif

    int   n_chk = 0;
    int   n_fail = 0;
    int   nf_cnt;
    vec_t tbl [10];
    exp_t sb [$];
    exp_t e;

    always #5 clk = ~clk;

    ctrl_pipe #(.RF_ADDR_W(5), .FWD_EN(1)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid), .id_instr_i(instr),
        .flush_i(flush), .mem_stall_i(mem_stall), .id_stall_o(stall), .ex_valid_o(ex_valid),
        .ex_cw_o(ex_cw), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .mem_valid_o(mem_valid),
        .mem_re_o(mem_re), .mem_we_o(mem_we), .wb_reg_we_o(wb_we), .wb_mem_to_reg_o(wb_m2r),
        .wb_rd_o(wb_rd)
`ifdef CTRL_ILLEGAL_TRAP_EN
        , .illegal_o(illegal)
`endif
    );

    ctrl_pipe #(.RF_ADDR_W(5), .FWD_EN(0)) dut_nofwd (
        .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid), .id_instr_i(instr),
        .flush_i(flush), .mem_stall_i(mem_stall), .id_stall_o(nf_stall), .ex_valid_o(nf_ex_valid),
        .ex_cw_o(nf_ex_cw), .fwd_a_o(nf_fwd_a), .fwd_b_o(nf_fwd_b), .mem_valid_o(nf_mem_valid),
        .mem_re_o(nf_mem_re), .mem_we_o(nf_mem_we), .wb_reg_we_o(nf_wb_we),
        .wb_mem_to_reg_o(nf_wb_m2r), .wb_rd_o(nf_wb_rd)
`ifdef CTRL_ILLEGAL_TRAP_EN
        , .illegal_o(nf_illegal)
`endif
    );

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd, rs1, rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, op};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins);
        id_valid = v;
        instr    = ins;
    endtask

    task automatic drain();
        drive(1'b0, 32'h0);
        repeat (3) step();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ex_valid"}, ex_valid, 0);   chk({tag, "_ex_cw"}, ex_cw, 0);
        chk({tag, "_fwd_a"}, fwd_a, 0);         chk({tag, "_fwd_b"}, fwd_b, 0);
        chk({tag, "_mem_valid"}, mem_valid, 0); chk({tag, "_mem_re"}, mem_re, 0);
        chk({tag, "_mem_we"}, mem_we, 0);       chk({tag, "_wb_we"}, wb_we, 0);
        chk({tag, "_wb_m2r"}, wb_m2r, 0);       chk({tag, "_wb_rd"}, wb_rd, 0);
        chk({tag, "_stall"}, stall, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{T_R,     CW_R};
        tbl[1] = '{T_I,     9'b100001000};
        tbl[2] = '{T_LD,    CW_LD};
        tbl[3] = '{T_ST,    CW_ST};
        tbl[4] = '{T_BR,    9'b011000010};
        tbl[5] = '{T_JAL,   9'b000001001};
        tbl[6] = '{T_JALR,  9'b000001001};
        tbl[7] = '{T_LUI,   CW_LUI};
        tbl[8] = '{T_AUIPC, 9'b000001000};
        tbl[9] = '{7'b0000000, 9'b000000000};

        rst_n = 1'b0; flush = 1'b0; mem_stall = 1'b0;
        drive(1'b0, 32'h0);
        repeat (2) step();
        check_zero("reset");
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk("reset_illegal", illegal, 0);
`endif
        @(negedge clk) rst_n = 1'b1;
        step();

        // Reset mid-stream with every stage valid
        drive(1'b1, mk(T_I, 5'd3, 5'd0, 5'd0));  step();
        drive(1'b1, mk(T_LD, 5'd4, 5'd0, 5'd0)); step();
        drive(1'b1, mk(T_R, 5'd6, 5'd0, 5'd0));  step();
        chk("prefill_mem_valid", mem_valid, 1);
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");
        drive(1'b0, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("postrst_ex_valid", ex_valid, 0);
        chk("postrst_mem_valid", mem_valid, 0);
        chk("postrst_wb_we", wb_we, 0);

        // Opcode table streamed back to back; scoreboard tracks EX/MEM/WB
        sb.delete();
        for (int i = 0; i < 12; i++) begin
            if (i < 10) begin
                drive(1'b1, mk(tbl[i].op, 5'(i + 1), 5'd0, 5'd0));
                sb.push_back('{1'b1, tbl[i].cw, 5'(i + 1)});
            end else begin
                drive(1'b0, 32'h0);
                sb.push_back('{1'b0, 9'd0, 5'd0});
            end
            step();
            e = sb[sb.size() - 1];
            chk($sformatf("tbl%0d_ex_valid", i), ex_valid, e.valid);
            chk($sformatf("tbl%0d_ex_cw", i), ex_cw, e.cw);
            chk($sformatf("tbl%0d_fwd", i), {fwd_a, fwd_b}, 0);
            if (sb.size() >= 2) begin
                e = sb[sb.size() - 2];
                chk($sformatf("tbl%0d_mem_valid", i), mem_valid, e.valid);
                chk($sformatf("tbl%0d_mem_re", i), mem_re, e.cw[5]);
                chk($sformatf("tbl%0d_mem_we", i), mem_we, e.cw[4]);
            end
            if (sb.size() == 3) begin
                e = sb.pop_front();
                chk($sformatf("tbl%0d_wb_we", i), wb_we, e.cw[3]);
                chk($sformatf("tbl%0d_wb_m2r", i), wb_m2r, e.cw[2]);
                chk($sformatf("tbl%0d_wb_rd", i), wb_rd, e.rd);
            end
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk("tbl_illegal_set", illegal, 1);
`endif

        // Load-use: lw x5 ; add x6,x5,x1
        drain();
        drive(1'b1, mk(T_LD, 5'd5, 5'd1, 5'd0)); step();
        drive(1'b1, mk(T_R, 5'd6, 5'd5, 5'd1));
        #1 chk("lu_stall", stall, 1);
        step();
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_bubble_cw", ex_cw, 0);
        chk("lu_stall_released", stall, 0);
        step();
        chk("lu_ex_cw", ex_cw, CW_R);
        chk("lu_fwd_a", fwd_a, 2'b10);
        chk("lu_fwd_b", fwd_b, 2'b00);

        // add x5 ; sub x7,x5,x5 -> MEM forwarding, two stalls without forwarding
        drain();
        drive(1'b1, mk(T_R, 5'd5, 5'd1, 5'd2)); step();
        drive(1'b1, mk(T_R, 5'd7, 5'd5, 5'd5) | 32'h4000_0000);
        #1 chk("raw_fwd_stall", stall, 0);
        nf_cnt = 0;
        if (nf_stall) nf_cnt++;
        step();
        chk("raw_fwd_a", fwd_a, 2'b01);
        chk("raw_fwd_b", fwd_b, 2'b01);
        for (int k = 0; k < 6; k++) begin
            if (!nf_stall) break;
            nf_cnt++;
            step();
        end
        chk("nofwd_stall_cycles", nf_cnt, 2);

        // Same with rd = x0
        drain();
        drive(1'b1, mk(T_R, 5'd0, 5'd1, 5'd2)); step();
        drive(1'b1, mk(T_R, 5'd7, 5'd0, 5'd0));
        #1 chk("x0_nofwd_stall", nf_stall, 0);
        step();
        chk("x0_fwd", {fwd_a, fwd_b}, 4'b0000);

        // MEM beats WB, then WB alone
        drain();
        drive(1'b1, mk(T_R, 5'd5, 5'd1, 5'd2)); step();
        drive(1'b1, mk(T_I, 5'd5, 5'd5, 5'd0)); step();
        drive(1'b1, mk(T_R, 5'd7, 5'd5, 5'd5)); step();
        chk("prio_fwd_a", fwd_a, 2'b01);
        chk("prio_fwd_b", fwd_b, 2'b01);
        drive(1'b1, mk(T_R, 5'd8, 5'd5, 5'd0)); step();
        chk("wb_fwd_a", fwd_a, 2'b10);
        chk("wb_fwd_b", fwd_b, 2'b00);

        // Flush overrides a pending load-use stall
        drain();
        drive(1'b1, mk(T_LD, 5'd5, 5'd1, 5'd0)); step();
        drive(1'b1, mk(T_R, 5'd6, 5'd5, 5'd1));
        flush = 1'b1;
        #1 chk("flush_stall", stall, 0);
        step();
        chk("flush_ex_valid", ex_valid, 0);
        chk("flush_mem_re", mem_re, 1);
        flush = 1'b0;

        // Memory stall freezes all stages for 3 cycles
        drain();
        drive(1'b1, mk(T_I, 5'd9, 5'd0, 5'd0));   step();
        drive(1'b1, mk(T_LD, 5'd10, 5'd0, 5'd0)); step();
        drive(1'b1, mk(T_ST, 5'd0, 5'd0, 5'd0));  step();
        drive(1'b1, mk(T_LUI, 5'd11, 5'd0, 5'd0));
        mem_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("ms%0d_stall", k), stall, 1);
            step();
            chk($sformatf("ms%0d_ex_cw", k), ex_cw, CW_ST);
            chk($sformatf("ms%0d_mem", k), {mem_valid, mem_re, mem_we}, 3'b110);
            chk($sformatf("ms%0d_wb", k), {wb_we, wb_m2r, wb_rd}, {2'b10, 5'd9});
        end
        mem_stall = 1'b0;
        step();
        chk("ms_rel_ex_cw", ex_cw, CW_LUI);
        chk("ms_rel_mem_we", mem_we, 1);
        chk("ms_rel_wb", {wb_we, wb_m2r, wb_rd}, {2'b11, 5'd10});

`ifdef CTRL_ILLEGAL_TRAP_EN
        drive(1'b0, 32'h0);
        rst_n = 1'b0;
        #1 chk("ill_cleared", illegal, 0);
        @(negedge clk) rst_n = 1'b1;
        drive(1'b1, 32'h0000_007F); step();
        chk("ill_set", illegal, 1);
        chk("ill_bubble_cw", ex_cw, 0);
        drive(1'b1, mk(T_R, 5'd1, 5'd0, 5'd0)); step();
        drive(1'b0, 32'h0); step();
        chk("ill_sticky", illegal, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
